// File: rtl/tank_plant_emulator.sv
// Closed-loop plant model of the irrigation tank and soil bed, ticked by a prescaler.
// Optional switch fault injection is enabled by defining TANK_FAULT_INJ_EN.
module tank_plant_emulator #(
  parameter int CAP        = 200,
  parameter int INIT_LEVEL = 0,
  parameter int TICK_DIV   = 50000,
  parameter int FILL_RATE  = 4,
  parameter int SPR_RATE   = 3,
  parameter int DRIP_RATE  = 1,
  parameter int L_TH       = 20,
  parameter int M_TH       = 100,
  parameter int H_TH       = 180,
  parameter int WET_TH     = 128,
  parameter int DRY_TH     = 64,
  parameter int DRY_RATE   = 1
) (
  input  logic       clock,
  input  logic       Rst,
  input  logic       Ve,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       clr,
`ifdef TANK_FAULT_INJ_EN
  input  logic [1:0] fault_sel,
`endif
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       Us,
  output logic [7:0] level,
  output logic [7:0] moisture,
  output logic       tick,
  output logic       ovf,
  output logic       dry_run
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [9:0] CAP10  = 10'(CAP);
  localparam logic [7:0] CAP8   = 8'(CAP);
  localparam logic [9:0] FILL10 = 10'(FILL_RATE);
  localparam logic [9:0] SPR10  = 10'(SPR_RATE);
  localparam logic [9:0] DRIP10 = 10'(DRIP_RATE);
  localparam logic [7:0] INIT8  = 8'(INIT_LEVEL);
  localparam logic [7:0] LTH8   = 8'(L_TH);
  localparam logic [7:0] MTH8   = 8'(M_TH);
  localparam logic [7:0] HTH8   = 8'(H_TH);
  localparam logic [7:0] WET8   = 8'(WET_TH);
  localparam logic [7:0] DRYT8  = 8'(DRY_TH);
  localparam logic [7:0] DRYR8  = 8'(DRY_RATE);
  localparam logic L_INIT = (INIT_LEVEL >= L_TH) ? 1'b1 : 1'b0;
  localparam logic M_INIT = (INIT_LEVEL >= M_TH) ? 1'b1 : 1'b0;
  localparam logic H_INIT = (INIT_LEVEL >= H_TH) ? 1'b1 : 1'b0;

  typedef enum logic {
    SOIL_DRY = 1'b0,
    SOIL_WET = 1'b1
  } soil_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [7:0]    level_q, level_d;
  logic [7:0]    moist_q, moist_d;
  logic          ovf_q, ovf_d;
  logic          dry_q, dry_d;
  soil_e         soil_q, soil_d;
  logic          h_q, h_d, m_q, m_d, l_q, l_d;

  logic [9:0]    in_s, dem_s, avail_s, del_s, net_s;
  logic [10:0]   wet_sum_s;
  logic [7:0]    decay_s;

  // Net water balance for one tick: inflow is usable by the outflow of the same tick.
  always_comb begin
    in_s      = Ve ? FILL10 : 10'd0;
    dem_s     = (Bs ? SPR10 : 10'd0) + (Vs ? DRIP10 : 10'd0);
    avail_s   = {2'b00, level_q} + in_s;
    del_s     = (dem_s < avail_s) ? dem_s : avail_s;
    net_s     = avail_s - del_s;
    wet_sum_s = {3'b000, moist_q} + {del_s, 1'b0};
    decay_s   = (moist_q > DRYR8) ? (moist_q - DRYR8) : 8'd0;
  end

  // Prescaler and plant next state; plant state only moves on the tick edge.
  always_comb begin
    cnt_d   = (cnt_q == TICK_LAST) ? {CW{1'b0}} : (cnt_q + CW'(1));
    tick_d  = (cnt_d == TICK_LAST);
    level_d = level_q;
    moist_d = moist_q;
    if (tick_q) begin
      level_d = (net_s > CAP10) ? CAP8 : net_s[7:0];
      if (del_s != 10'd0) begin
        moist_d = (wet_sum_s > 11'd255) ? 8'd255 : wet_sum_s[7:0];
      end else begin
        moist_d = decay_s;
      end
    end else begin
      level_d = level_q;
      moist_d = moist_q;
    end
    // A set condition on the tick edge beats a simultaneous clear.
    if (tick_q && Ve && (avail_s > CAP10)) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (tick_q && Bs && (avail_s < SPR10)) begin
      dry_d = 1'b1;
    end else if (clr) begin
      dry_d = 1'b0;
    end else begin
      dry_d = dry_q;
    end
  end

  // Soil humidity hysteresis, evaluated from the registered moisture.
  always_comb begin
    soil_d = soil_q;
    case (soil_q)
      SOIL_DRY: begin
        if (moist_q >= WET8) soil_d = SOIL_WET;
        else                 soil_d = SOIL_DRY;
      end
      SOIL_WET: begin
        if (moist_q < DRYT8) soil_d = SOIL_DRY;
        else                 soil_d = SOIL_WET;
      end
      default: soil_d = SOIL_DRY;
    endcase
  end

  // Level switches, with optional overrides that deliberately break H=>M=>L.
  always_comb begin
    l_d = (level_q >= LTH8);
    m_d = (level_q >= MTH8);
    h_d = (level_q >= HTH8);
`ifdef TANK_FAULT_INJ_EN
    case (fault_sel)
      2'd1:    l_d = 1'b0;
      2'd2:    m_d = 1'b1;
      2'd3:    h_d = 1'b1;
      default: l_d = (level_q >= LTH8);
    endcase
`endif
  end

  // State registers.
  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      cnt_q   <= {CW{1'b0}};
      tick_q  <= 1'b0;
      level_q <= INIT8;
      moist_q <= 8'd0;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
      soil_q  <= SOIL_DRY;
      h_q     <= H_INIT;
      m_q     <= M_INIT;
      l_q     <= L_INIT;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      moist_q <= moist_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
      soil_q  <= soil_d;
      h_q     <= h_d;
      m_q     <= m_d;
      l_q     <= l_d;
    end
  end

  assign tick     = tick_q;
  assign level    = level_q;
  assign moisture = moist_q;
  assign ovf      = ovf_q;
  assign dry_run  = dry_q;
  assign Us       = (soil_q == SOIL_WET);
  assign H        = h_q;
  assign M        = m_q;
  assign L        = l_q;

endmodule
